// File: rtl/ram_arb_pkg.sv
// Shared encodings for the ram_arb fetch/LSU single-port RAM arbiter.
package ram_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSP_IF = 2'd1,
        ST_RSP_LS = 2'd2
    } rsp_state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // True when the access cannot be served by a single aligned RAM word.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_bad_access = 1'b0;
            SZ_HALF: is_bad_access = off[0];
            SZ_WORD: is_bad_access = (off != 2'b00);
            default: is_bad_access = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_arb_ldext.sv
// Load extension: aligns the RAM word by byte offset, truncates to size, sign/zero-extends.
module ram_arb_ldext
    import ram_arb_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = word >> {off, 3'b000};

    always_comb begin
        data = sh;
        case (size)
            SZ_BYTE: data = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: data = {{16{~uns & sh[15]}}, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/ram_arb.sv
// Fetch/LSU arbiter in front of a byte-lane RAM with one-cycle read latency.
// Optional macro RAM_ARB_RR_EN: round-robin on contention instead of fixed LSU priority.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_size,
    input  logic          ls_unsigned,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic          ls_err,
    output logic [DW-1:0] ls_rdata,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_ren,
    input  logic [DW-1:0] ram_rdata
);

    rsp_state_t  state, state_nxt;
    logic        contend, ls_bad;
    logic [1:0]  off_q, size_q;
    logic        uns_q, we_q, err_q;
    logic [31:0] ld_data;
    logic        unused_addr;

    assign unused_addr = ^if_addr[1:0];
    assign contend     = rstn & if_req & ls_req;
    assign ls_bad      = is_bad_access(ls_size, ls_addr[1:0]);

`ifdef RAM_ARB_RR_EN
    // ptr_if=1 means fetch wins the next contended cycle.
    logic ptr_if;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        ptr_if <= 1'b1;
        else if (contend) ptr_if <= ~ptr_if;
    end

    assign if_gnt = rstn & if_req & (~ls_req | ptr_if);
    assign ls_gnt = rstn & ls_req & (~if_req | ~ptr_if);
`else
    assign if_gnt = rstn & if_req & ~ls_req;
    assign ls_gnt = rstn & ls_req;
`endif

    // RAM request side: grant gates every enable so idle cycles stay quiet.
    assign ram_ren   = if_gnt | (ls_gnt & ~ls_we & ~ls_bad);
    assign ram_raddr = ls_gnt ? {ls_addr[AW-1:2], 2'b00} : {if_addr[AW-1:2], 2'b00};
    assign ram_waddr = {ls_addr[AW-1:2], 2'b00};

    always_comb begin
        ram_wen   = 4'b0000;
        ram_wdata = ls_wdata;
        case (ls_size)
            SZ_BYTE: ram_wdata = {4{ls_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{ls_wdata[15:0]}};
            default: ram_wdata = ls_wdata;
        endcase
        if (ls_gnt && ls_we && !ls_bad) begin
            case (ls_size)
                SZ_BYTE: ram_wen = MASK_BYTE << ls_addr[1:0];
                SZ_HALF: ram_wen = MASK_HALF << {ls_addr[1], 1'b0};
                default: ram_wen = MASK_WORD;
            endcase
        end
    end

    // LSU attributes needed to format the response one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            off_q  <= 2'b00;
            size_q <= SZ_BYTE;
            uns_q  <= 1'b0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (ls_gnt) begin
            off_q  <= ls_addr[1:0];
            size_q <= ls_size;
            uns_q  <= ls_unsigned;
            we_q   <= ls_we;
            err_q  <= ls_bad;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        if (ls_gnt)      state_nxt = ST_RSP_LS;
        else if (if_gnt) state_nxt = ST_RSP_IF;
    end

    ram_arb_ldext u_ldext (
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .word (ram_rdata),
        .data (ld_data)
    );

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rvalid = 1'b0;
        ls_err    = 1'b0;
        ls_rdata  = '0;
        case (state)
            ST_RSP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = ram_rdata;
            end
            ST_RSP_LS: begin
                ls_rvalid = 1'b1;
                ls_err    = err_q;
                if (!err_q && !we_q) ls_rdata = ld_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb: directed requests push expected responses, a monitor checks them.
module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_waddr, ram_raddr, ram_wdata;
    logic        ram_ren;
    logic [31:0] ram_rdata = 32'h0;

    typedef struct packed {
        logic        is_ls;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    ram_arb dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_rdata(ram_rdata)
    );

    // Byte-lane RAM with one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) mem[ram_waddr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
        if (ram_ren) ram_rdata <= mem[ram_raddr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (if_rvalid || ls_rvalid) begin
            check("single_rvalid", {31'd0, if_rvalid & ls_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_port", {31'd0, ls_rvalid}, {31'd0, e.is_ls});
                if (e.is_ls) begin
                    check("ls_err", {31'd0, ls_err}, {31'd0, e.err});
                    check("ls_rdata", ls_rdata, e.data);
                end else begin
                    check("if_rdata", if_rdata, e.data);
                end
            end
        end
    end

    task automatic clear_in();
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
        ls_unsigned = 0; ls_addr = 0; ls_wdata = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_gnt"},   {30'd0, if_gnt, ls_gnt}, 32'd0);
        check({name, "_rv"},    {29'd0, if_rvalid, ls_rvalid, ls_err}, 32'd0);
        check({name, "_rdata"}, if_rdata | ls_rdata, 32'd0);
        check({name, "_ram"},   {27'd0, ram_wen, ram_ren}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data);
        if_req = 1; if_addr = addr;
        @(negedge clk);
        check("if_gnt", {31'd0, if_gnt}, 32'd1);
        check("if_ren", {31'd0, ram_ren}, 32'd1);
        check("if_raddr", ram_raddr, addr);
        exp_q.push_back('{is_ls: 1'b0, err: 1'b0, data: exp_data});
        step(); clear_in();
    endtask

    task automatic ls_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                         input logic exp_ren, input logic exp_err, input logic [31:0] exp_rdata);
        ls_req = 1; ls_we = we; ls_size = size; ls_unsigned = uns; ls_addr = addr; ls_wdata = wdata;
        @(negedge clk);
        check("ls_gnt", {31'd0, ls_gnt}, 32'd1);
        check("ls_wen", {28'd0, ram_wen}, {28'd0, exp_wen});
        check("ls_ren", {31'd0, ram_ren}, {31'd0, exp_ren});
        if (exp_wen != 0) begin
            check("ls_wdata", ram_wdata, exp_wdata);
            check("ls_waddr", ram_waddr, {addr[31:2], 2'b00});
        end
        if (exp_ren) check("ls_raddr", ram_raddr, {addr[31:2], 2'b00});
        exp_q.push_back('{is_ls: 1'b1, err: exp_err, data: exp_rdata});
        step(); clear_in();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;

        clear_in();
        rstn = 0;
        if_req = 1; ls_req = 1;  // requests during reset must not be granted
        @(negedge clk);
        check_quiet("reset");
        step(); step();
        rstn = 1;
        clear_in();
        step();

        fetch(32'h100, 32'hDEADBEEF);

        // byte store then signed/unsigned byte loads
        ls_op(1, 2'd0, 0, 32'h203, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0);
        ls_op(0, 2'd0, 0, 32'h203, 32'h0, 4'b0000, 32'h0, 1, 0, 32'hFFFFFFA5);
        ls_op(0, 2'd0, 1, 32'h203, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h000000A5);

        // half store at upper lanes, signed/unsigned half loads
        ls_op(1, 2'd1, 0, 32'h206, 32'h12348001, 4'b1100, 32'h80018001, 0, 0, 32'h0);
        ls_op(0, 2'd1, 0, 32'h206, 32'h0, 4'b0000, 32'h0, 1, 0, 32'hFFFF8001);
        ls_op(0, 2'd1, 1, 32'h206, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h00008001);
        ls_op(0, 2'd0, 0, 32'h201, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h00000000);

        // word store/load
        ls_op(1, 2'd2, 0, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0, 0, 32'h0);
        ls_op(0, 2'd2, 0, 32'h300, 32'h0, 4'b0000, 32'h0, 1, 0, 32'hCAFEF00D);

        // misaligned / illegal: granted, no RAM access, error response
        ls_op(0, 2'd2, 0, 32'h102, 32'h0, 4'b0000, 32'h0, 0, 1, 32'h0);
        ls_op(1, 2'd1, 0, 32'h205, 32'hFFFF, 4'b0000, 32'h0, 0, 1, 32'h0);
        ls_op(0, 2'd3, 0, 32'h200, 32'h0, 4'b0000, 32'h0, 0, 1, 32'h0);
        ls_op(0, 2'd0, 1, 32'h206, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h00000001);

        // contention for 4 back-to-back cycles
        for (int i = 0; i < 4; i++) begin
            logic exp_if;
`ifdef RAM_ARB_RR_EN
            exp_if = (i % 2 == 0);
`else
            exp_if = 1'b0;
`endif
            if_req = 1; if_addr = 32'h100;
            ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_unsigned = 0; ls_addr = 32'h300;
            @(negedge clk);
            check("cont_gnt", {30'd0, if_gnt, ls_gnt}, {30'd0, exp_if, ~exp_if});
            check("cont_raddr", ram_raddr, exp_if ? 32'h100 : 32'h300);
            if (exp_if) exp_q.push_back('{is_ls: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
            else        exp_q.push_back('{is_ls: 1'b1, err: 1'b0, data: 32'hCAFEF00D});
            step();
        end
        clear_in();
        step();

        // reset in the response cycle of a fetch: response discarded
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("rst_if_gnt", {31'd0, if_gnt}, 32'd1);
        step();
        rstn = 0;
        clear_in();
        @(negedge clk);
        check_quiet("midreset");
        step();
        rstn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            step();
        end

        check("pending_rsp", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter AW, default 32, byte-address width of both requester ports and the RAM ports.
REQ-002 Parameter DW, default 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  AW  fetch byte address, word-aligned.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 ls_req, ls_we  input  1 each  load/store request; write when ls_we=1.
REQ-011 ls_size  input  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-012 ls_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-013 ls_addr, ls_wdata  input  AW, 32  load/store byte address and store data (LSB-justified).
REQ-014 ls_gnt, ls_rvalid, ls_err  output  1 each  accepted; response valid; response is an error.
REQ-015 ls_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 ram_wen  output  4  per-byte write enables to the byte-lane RAM.
REQ-017 ram_waddr, ram_raddr  output  AW  RAM byte addresses, forced word-aligned (low 2 bits 0).
REQ-018 ram_wdata  output  32  lane-replicated write data.
REQ-019 ram_ren  output  1  RAM read enable.
REQ-020 ram_rdata  input  32  RAM read data, valid the cycle after ram_ren.

Function
REQ-021 The block SHALL grant at most one requester per cycle; each grant is combinational in the request cycle.
REQ-022 The block SHALL give LSU fixed priority over fetch when both request in the same cycle (default build).
REQ-023 A granted read SHALL assert ram_ren with the word address; rvalid SHALL assert to the granted requester exactly one cycle later.
REQ-024 A granted aligned store SHALL drive ram_wen/ram_wdata in the grant cycle, and ls_rvalid=1 with ls_rdata=0 one cycle later.
REQ-025 ram_wen: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
REQ-026 ram_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-027 Load data SHALL be ram_rdata shifted right by 8*addr[1:0] (registered offset), then truncated to size and sign- or zero-extended per the registered ls_unsigned.
REQ-028 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 3 SHALL be granted with ram_wen=0 and ram_ren=0; the response cycle gives ls_rvalid=1, ls_err=1, ls_rdata=0.
REQ-029 Response tracking SHALL be a 3-state register: IDLE, RSP_IF, RSP_LS; the next state is taken from the current grant, so back-to-back grants sustain one response per cycle.
REQ-030 The response pipeline SHALL have no backpressure; requesters accept rvalid unconditionally.
REQ-031 ram_wen and ram_ren SHALL be 0 in every cycle without a valid grant.

Reset
REQ-032 While rstn=0: state IDLE; all gnt/rvalid/err = 0; all rdata = 0; ram_wen=0; ram_ren=0; the round-robin pointer points to fetch.
REQ-033 A response pending at reset assertion SHALL be discarded, with no rvalid after release.

Configuration
REQ-034 With RAM_ARB_RR_EN defined, simultaneous requests SHALL alternate: the winner is the requester not granted at the last contended cycle, and the pointer updates only on contention. Without the macro, fixed LSU priority per REQ-022 applies.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the response-state encoding, and the lane-mask constants.
REQ-036 The load-extension logic SHALL be one sub-module, ram_arb_ldext (offset, size, unsigned, word in -> 32-bit out).

Verification
REQ-037 Fetch alone at 0x100, RAM word 0xDEADBEEF -> if_gnt same cycle, ram_ren=1, ram_raddr=0x100, if_rvalid next cycle, if_rdata=0xDEADBEEF.
REQ-038 Store byte 0xA5 at 0x203 -> ram_wen=4'b1000, ram_wdata=0xA5A5A5A5, ls_rvalid next cycle; a signed byte load at 0x203 -> ls_rdata=0xFFFFFFA5, an unsigned one -> 0x000000A5.
REQ-039 Fetch and LSU requesting together for 4 cycles -> default: LSU granted all 4; RAM_ARB_RR_EN: grants alternate IF, LS, IF, LS starting from reset.
REQ-040 Word load at 0x102 -> ls_gnt=1, ram_ren=0, next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
REQ-041 rstn pulled low the cycle after a fetch grant -> no if_rvalid follows, and all outputs read 0 during reset.
